// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : led_pkg                                                         |
// | Purpose  : Shared LED channel mode encoding and mode field width.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    BLINK   = 2'd2,
    BREATHE = 2'd3
  } led_mode_t;

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : led_channel                                                     |
// | Purpose  : One LED channel: mode/half-period registers, tick counter,      |
// |            blink phase and (with LED_PATTERN_BREATHE_EN) breathing duty.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module led_channel
  import led_pkg::*;
#(
  parameter int PERIOD_W        = 16,
`ifdef LED_PATTERN_BREATHE_EN
  parameter int PWM_W           = 8,
`endif
  parameter int DEF_HALF_PERIOD = 500
) (
  input  logic                i_sys_clk,
  input  logic                i_rst_n,
  input  logic                i_tick,
  input  logic                i_wr,
  input  logic [MODE_W-1:0]   i_mode,
  input  logic [PERIOD_W-1:0] i_half_period,
`ifdef LED_PATTERN_BREATHE_EN
  input  logic [PWM_W-1:0]    i_carrier,
`endif
  output logic                o_led
);

  localparam logic [PERIOD_W-1:0] c_one = PERIOD_W'(1);

  led_mode_t           r_mode;
  logic [PERIOD_W-1:0] r_half_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_led;
  logic [PERIOD_W-1:0] w_half_eff;
  logic                w_wrap;
  logic                w_lit_on_write;

  // A programmed half-period of zero behaves as one tick.
  assign w_half_eff = (r_half_period == '0) ? c_one : r_half_period;
  assign w_wrap     = i_tick && (r_cnt == (w_half_eff - c_one));

  always_comb begin
    w_lit_on_write = 1'b0;
    case (led_mode_t'(i_mode))
      ON, BLINK: w_lit_on_write = 1'b1;
`ifndef LED_PATTERN_BREATHE_EN
      BREATHE:   w_lit_on_write = 1'b1;
`endif
      default:   w_lit_on_write = 1'b0;
    endcase
  end

`ifdef LED_PATTERN_BREATHE_EN
  localparam logic [PWM_W-1:0] c_duty_max = '1;
  localparam logic [PWM_W-1:0] c_duty_one = PWM_W'(1);

  logic [PWM_W-1:0] r_duty;
  logic             r_up;

  // Triangle ramp: one step per half-period, turning around at both ends.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty <= '0;
      r_up   <= 1'b1;
    end else if (i_wr) begin
      r_duty <= '0;
      r_up   <= 1'b1;
    end else if (w_wrap && (r_mode == BREATHE)) begin
      if (r_up) begin
        r_duty <= r_duty + c_duty_one;
        if (r_duty == (c_duty_max - c_duty_one)) r_up <= 1'b0;
      end else begin
        r_duty <= r_duty - c_duty_one;
        if (r_duty == c_duty_one) r_up <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode        <= BLINK;
      r_half_period <= PERIOD_W'(DEF_HALF_PERIOD);
      r_cnt         <= '0;
      r_led         <= 1'b0;
    end else if (i_wr) begin
      r_mode        <= led_mode_t'(i_mode);
      r_half_period <= i_half_period;
      r_cnt         <= '0;
      r_led         <= w_lit_on_write;
    end else begin
      if (i_tick) r_cnt <= w_wrap ? '0 : (r_cnt + c_one);
      case (r_mode)
        OFF:     r_led <= 1'b0;
        ON:      r_led <= 1'b1;
        BLINK:   if (w_wrap) r_led <= ~r_led;
`ifdef LED_PATTERN_BREATHE_EN
        BREATHE: r_led <= (i_carrier < r_duty);
`else
        BREATHE: r_led <= 1'b1;
`endif
        default: r_led <= 1'b0;
      endcase
    end
  end

  assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : led_pattern_engine                                              |
// | Purpose  : Multi-channel LED pattern generator (off/on/blink/breathe) with |
// |            shared tick prescaler and PWM carrier. Breathing is built only  |
// |            when LED_PATTERN_BREATHE_EN is defined; otherwise mode 3 = ON.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int NUM_LEDS        = 4,
  parameter int CLK_HZ          = 27_000_000,
  parameter int TICK_HZ         = 1000,
  parameter int PERIOD_W        = 16,
  parameter int PWM_W           = 8,
  parameter int DEF_HALF_PERIOD = 500,
  parameter int CH_W            = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                i_sys_clk,
  input  logic                i_rst_n,
  input  logic                i_cfg_wr,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [MODE_W-1:0]   i_cfg_mode,
  input  logic [PERIOD_W-1:0] i_cfg_half_period,
  output logic                o_cfg_ack,
  output logic                o_tick,
  output logic [NUM_LEDS-1:0] o_led
);

  localparam int                    c_div      = CLK_HZ / TICK_HZ;
  localparam int                    c_presc_w  = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_presc_w-1:0]  c_term     = c_presc_w'(c_div - 1);
  localparam logic [c_presc_w-1:0]  c_presc_1  = c_presc_w'(1);
  localparam logic [CH_W:0]         c_num_leds = (CH_W + 1)'(NUM_LEDS);

  if (NUM_LEDS < 1 || NUM_LEDS > 16 || PWM_W < 1 || PERIOD_W < 1 ||
      (CLK_HZ % TICK_HZ) != 0 || c_div < 2) begin : g_param_check
    $error("led_pattern_engine: illegal parameter combination");
  end

  logic [c_presc_w-1:0] r_presc;
  logic                 r_tick;
  logic                 r_ack;
  logic                 w_wr_ok;
  logic [NUM_LEDS-1:0]  w_led;

  // Writes to channel indices beyond NUM_LEDS are dropped silently.
  assign w_wr_ok = i_cfg_wr && ({1'b0, i_cfg_ch} < c_num_leds);

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_presc <= (r_presc == c_term) ? '0 : (r_presc + c_presc_1);
      r_tick  <= (r_presc == c_term);
      r_ack   <= w_wr_ok;
    end
  end

`ifdef LED_PATTERN_BREATHE_EN
  logic [PWM_W-1:0] r_carrier;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_carrier <= '0;
    else          r_carrier <= r_carrier + PWM_W'(1);
  end
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_channel #(
      .PERIOD_W        (PERIOD_W),
`ifdef LED_PATTERN_BREATHE_EN
      .PWM_W           (PWM_W),
`endif
      .DEF_HALF_PERIOD (DEF_HALF_PERIOD)
    ) u_channel (
      .i_sys_clk     (i_sys_clk),
      .i_rst_n       (i_rst_n),
      .i_tick        (r_tick),
      .i_wr          (w_wr_ok && (i_cfg_ch == CH_W'(i))),
      .i_mode        (i_cfg_mode),
      .i_half_period (i_cfg_half_period),
`ifdef LED_PATTERN_BREATHE_EN
      .i_carrier     (r_carrier),
`endif
      .o_led         (w_led[i])
    );
  end

  assign o_cfg_ack = r_ack;
  assign o_tick    = r_tick;
  assign o_led     = w_led;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_led_pattern_engine                                           |
// | Purpose  : Scoreboard bench; a tick-count reference model predicts LED,    |
// |            tick and ack outputs for every clock cycle.                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_led_pattern_engine;
  import led_pkg::*;

  localparam int NUM_LEDS = 4;
  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int PERIOD_W = 16;
  localparam int PWM_W    = 8;
  localparam int DEF_HP   = 500;
  localparam int CH_W     = 3;
  localparam int DUTY_MAX = (1 << PWM_W) - 1;
`ifdef LED_PATTERN_BREATHE_EN
  localparam bit BREATHE_EN = 1'b1;
`else
  localparam bit BREATHE_EN = 1'b0;
`endif

  logic                sys_clk = 1'b0;
  logic                rst_n   = 1'b0;
  logic                cfg_wr  = 1'b0;
  logic [CH_W-1:0]     cfg_ch  = '0;
  logic [MODE_W-1:0]   cfg_mode = '0;
  logic [PERIOD_W-1:0] cfg_hp  = '0;
  logic                cfg_ack;
  logic                tick;
  logic [NUM_LEDS-1:0] led;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  led_pattern_engine #(
    .NUM_LEDS(NUM_LEDS), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .PERIOD_W(PERIOD_W),
    .PWM_W(PWM_W), .DEF_HALF_PERIOD(DEF_HP), .CH_W(CH_W)
  ) dut (
    .i_sys_clk(sys_clk), .i_rst_n(rst_n), .i_cfg_wr(cfg_wr), .i_cfg_ch(cfg_ch),
    .i_cfg_mode(cfg_mode), .i_cfg_half_period(cfg_hp),
    .o_cfg_ack(cfg_ack), .o_tick(tick), .o_led(led)
  );

  // ---------------- reference model ----------------
  logic [NUM_LEDS+1:0] exp_q[$];
  int m_mode[NUM_LEDS], m_hp[NUM_LEDS], m_ticks[NUM_LEDS], m_phase0[NUM_LEDS];
  int mdl_edge, old_t;
  bit mdl_tick_pre, mdl_wr_ok;
  logic [NUM_LEDS-1:0] mdl_led;

  function automatic int tri_duty(input int steps);
    int v;
    v = steps % (2 * DUTY_MAX);
    return (v <= DUTY_MAX) ? v : (2 * DUTY_MAX - v);
  endfunction

  function automatic logic lit_on_write(input int mode);
    return (mode == 1) || (mode == 2) || (mode == 3 && !BREATHE_EN);
  endfunction

  function automatic logic chan_led(input int mode, input int hp, input int t_new,
                                    input int t_old, input int phase0, input int carrier);
    int hpe;
    hpe = (hp == 0) ? 1 : hp;
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'(phase0 ^ ((t_new / hpe) % 2));
      default: return BREATHE_EN ? (carrier < tri_duty(t_old / hpe)) : 1'b1;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    if (!rst_n) begin
      mdl_edge = 0;
      for (int c = 0; c < NUM_LEDS; c++) begin
        m_mode[c] = 2; m_hp[c] = DEF_HP; m_ticks[c] = 0; m_phase0[c] = 0;
      end
      exp_q.push_back('0);
    end else begin
      mdl_tick_pre = (mdl_edge > 0) && (mdl_edge % DIV == 0);
      mdl_edge++;
      mdl_wr_ok = cfg_wr && (int'(cfg_ch) < NUM_LEDS);
      for (int c = 0; c < NUM_LEDS; c++) begin
        if (mdl_wr_ok && int'(cfg_ch) == c) begin
          m_mode[c] = int'(cfg_mode); m_hp[c] = int'(cfg_hp);
          m_ticks[c] = 0; m_phase0[c] = 1;
          mdl_led[c] = lit_on_write(m_mode[c]);
        end else begin
          old_t = m_ticks[c];
          if (mdl_tick_pre) m_ticks[c]++;
          mdl_led[c] = chan_led(m_mode[c], m_hp[c], m_ticks[c], old_t, m_phase0[c],
                                (mdl_edge - 1) % (1 << PWM_W));
        end
      end
      exp_q.push_back({mdl_led, (mdl_edge % DIV == 0), mdl_wr_ok});
    end
  end

  // ---------------- monitor ----------------
  logic [NUM_LEDS+1:0] exp_v;
  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({led, tick, cfg_ack} !== exp_v) begin
        errors++;
        $display("FAIL outputs @%0t: got led=%b tick=%b ack=%b, want led=%b tick=%b ack=%b",
                 $time, led, tick, cfg_ack, exp_v[NUM_LEDS+1:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_write(input int ch, input int mode, input int hp);
    cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_mode = MODE_W'(mode); cfg_hp = PERIOD_W'(hp);
  endtask

  task automatic do_write(input int ch, input int mode, input int hp);
    @(negedge sys_clk);
    drive_write(ch, mode, hp);
    @(negedge sys_clk);
    cfg_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(11000);                       // default blink: rise at 500 ticks, fall at 1000

    do_write(1, 2, 3);                 // ch1 blink, 3-tick half-period
    do_write(2, 0, 7);                 // ch2 off
    do_write(0, 2, 0);                 // ch0 half-period 0 -> toggles every tick
    idle(120);
    do_write(2, 1, 0);                 // ch2 on
    do_write(5, 1, 4);                 // out of range, ignored
    @(negedge sys_clk);                // back-to-back writes
    drive_write(3, 0, 1);
    @(negedge sys_clk);
    drive_write(2, 2, 2);
    @(negedge sys_clk);
    drive_write(7, 0, 0);
    @(negedge sys_clk);
    cfg_wr = 1'b0;
    idle(60);

    found = 1'b0;                      // write landing on a tick cycle
    for (int k = 0; k < 4 * DIV; k++) begin
      @(negedge sys_clk);
      if (tick) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tick_wait: got no tick within %0d cycles, want one every %0d", 4 * DIV, DIV);
    end else begin
      drive_write(1, 2, 2);
      @(negedge sys_clk);
      cfg_wr = 1'b0;
    end
    idle(80);

    for (int k = 0; k < 3000; k++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 7) == 0)
        drive_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 6)));
      else
        cfg_wr = 1'b0;
    end
    @(negedge sys_clk);
    cfg_wr = 1'b0;

    do_write(2, 1, 0);                 // keep one LED lit across the reset check
    do_write(3, 3, 1);                 // breathe, one step per tick
    idle(5300);                        // full ramp up, down and turn-around

    @(negedge sys_clk);
    drive_write(0, 1, 0);
    @(negedge sys_clk);
    cfg_wr = 1'b0;
    #2 rst_n = 1'b0;                   // asynchronous assert between edges
    #1;
    checks++;
    if ({led, tick, cfg_ack} !== '0) begin
      errors++;
      $display("FAIL async_reset: got led=%b tick=%b ack=%b, want all zero", led, tick, cfg_ack);
    end
    idle(3);
    rst_n = 1'b1;
    idle(5200);                        // pattern restarts from reset values

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, number of independent LED channels (1..16).
REQ-002 SHALL have parameter CLK_HZ, default 27_000_000, system clock frequency in Hz.
REQ-003 SHALL have parameter TICK_HZ, default 1000, pattern time-base rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-004 SHALL have parameter PERIOD_W, default 16, width of per-channel half-period field in ticks.
REQ-005 SHALL have parameter PWM_W, default 8, breathing duty/carrier width.
REQ-006 SHALL have parameter DEF_HALF_PERIOD, default 500, per-channel half-period loaded at reset.
REQ-007 i_sys_clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-008 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 i_cfg_wr  input  1  single-cycle config write strobe.
REQ-010 i_cfg_ch  input  $clog2(NUM_LEDS) (min 1)  target channel index.
REQ-011 i_cfg_mode  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
REQ-012 i_cfg_half_period  input  PERIOD_W  half-period in ticks.
REQ-013 o_cfg_ack  output  1  one-cycle pulse acknowledging an accepted write.
REQ-014 o_tick  output  1  one-cycle time-base pulse.
REQ-015 o_led  output  NUM_LEDS  registered LED drive, 1 = lit.

Function
REQ-016 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and wrap; o_tick SHALL be 1 for exactly the cycle after the count equals the terminal value.
REQ-017 Half-period 0 SHALL be treated as 1 in every mode.
REQ-018 OFF: o_led[i]=0; ON: o_led[i]=1; both independent of ticks.
REQ-019 BLINK: per-channel tick counter SHALL increment on o_tick; upon reaching half-period it SHALL clear and o_led[i] SHALL toggle on the next clock edge.
REQ-020 BREATHE: free-running PWM_W carrier counter increments every clock; o_led[i] = (carrier < duty[i]); duty SHALL step by 1 every half-period ticks, ramping up to 2^PWM_W-1, then down to 0, reversing at each end (triangle, no dwell beyond one step).
REQ-021 Write with i_cfg_ch < NUM_LEDS SHALL update mode and half-period at the next edge, clear the channel tick counter, set BLINK phase to lit, set duty 0 direction up; o_cfg_ack SHALL pulse the following cycle.
REQ-022 Write with i_cfg_ch >= NUM_LEDS SHALL be ignored with no o_cfg_ack.
REQ-023 Write coinciding with a tick SHALL win for the written channel; that tick SHALL not advance it; other channels advance normally.
REQ-024 Back-to-back writes (consecutive cycles) SHALL each be accepted and each acknowledged.

Reset
REQ-025 On i_rst_n low, all channels SHALL become BLINK with DEF_HALF_PERIOD, tick counters 0, duty 0 direction up, prescaler 0.
REQ-026 During reset o_led=0, o_tick=0, o_cfg_ack=0; first BLINK toggle (to lit) SHALL occur DEF_HALF_PERIOD ticks after release.
REQ-027 Reset asserted mid-pattern SHALL force reset values immediately, independent of clock.

Configuration
REQ-028 Macro LED_PATTERN_BREATHE_EN: defined, BREATHE mode, carrier and duty logic SHALL be present; undefined, they SHALL be absent and mode 3 SHALL behave as ON.

Structure
REQ-029 Package led_pkg SHALL hold the led_mode_t enum (OFF, ON, BLINK, BREATHE) and the mode-width constant.
REQ-030 Per-channel logic SHALL be sub-module led_channel, instantiated NUM_LEDS times by generate; prescaler and carrier remain shared in the top.

Verification (bench: CLK_HZ=1000, TICK_HZ=100 -> tick every 10 cycles, NUM_LEDS=4)
REQ-031 Reset release, no writes -> o_tick period 10 cycles; all o_led rise after 500 ticks and toggle every 500 ticks.
REQ-032 Write ch1 BLINK half-period 3 -> ack next cycle, o_led[1]=1 immediately after write, toggles every 30 cycles.
REQ-033 Write ch2 OFF then ON, ch0 half-period 0 -> o_led[2] 0 then 1; o_led[0] toggles every tick.
REQ-034 Write ch3 BREATHE half-period 1 (macro defined) -> high-time per 256-cycle carrier rises 0->255 over 255 ticks then falls; undefined -> o_led[3]=1 constant.
REQ-035 Write ch_idx 5 (NUM_LEDS=4 with 3-bit override bench) -> no ack, no o_led change; write on tick cycle -> written channel counter 0.
REQ-036 Assert i_rst_n mid-breathe between clock edges -> o_led, o_cfg_ack, o_tick 0 before next edge; patterns restart per REQ-025.
